// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared definitions for the reaction timer: FSM encoding, LFSR constants,
// delay base and the BCD saturation value.
package reaction_timer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DELAY  = 3'd1,
        ST_TIMING = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
    // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10
    localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;
    localparam logic [10:0] DELAY_BASE        = 11'd1000;
    localparam logic [15:0] BCD_MAX           = 16'h9999;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/reaction_timer_ctrl_bcd_counter4.sv
// Four-digit BCD counter (digit 0 = thousandths) with clear, increment
// enable and saturation at 9.999.
module bcd_counter4
    import reaction_timer_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [3:0][3:0]  digits,
    output logic             at_max
);

    logic [3:0][3:0] digits_q;
    logic [3:0][3:0] digits_d;
    logic            carry_s;
    logic            at_max_s;

    assign at_max_s = (digits_q == BCD_MAX);
    assign at_max   = at_max_s;
    assign digits   = digits_q;

    // Next digit values: ripple carry from thousandths upward, hold at max
    always_comb begin
        digits_d = digits_q;
        carry_s  = 1'b1;
        if (clr) begin
            digits_d = '0;
        end else if (inc && !at_max_s) begin
            for (int i = 0; i < 4; i++) begin
                if (carry_s && (digits_q[i] == 4'd9)) begin
                    digits_d[i] = 4'd0;
                end else if (carry_s) begin
                    digits_d[i] = digits_q[i] + 4'd1;
                    carry_s     = 1'b0;
                end else begin
                    digits_d[i] = digits_q[i];
                end
            end
        end else begin
            digits_d = digits_q;
        end
    end

    // Digit register
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= '0;
        end else begin
            digits_q <= digits_d;
        end
    end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer controller: random go-delay from an LFSR, then a 1 ms BCD
// stopwatch stopped by the player; early stop is reported as a fault.
module reaction_timer_ctrl
    import reaction_timer_ctrl_pkg::*;
#(
    parameter int unsigned  TICK_DIV  = 50000,
    parameter logic [15:0]  LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic [3:0]  ones,
    output logic [3:0]  tenths,
    output logic [3:0]  hundreths,
    output logic [3:0]  thousandths,
    output logic        disp_en,
    output logic        led,
    output logic        overflow,
    output logic [2:0]  state
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [10:0]     delay_q, delay_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            overflow_q, overflow_d;
    logic            tick_s;
    logic            presc_clr_s;
    logic            cnt_clr_s;
    logic            cnt_inc_s;
    logic            at_max_s;
    logic [3:0][3:0] digits_s;

    assign tick_s = (presc_q == PW'(TICK_DIV - 1));

    bcd_counter4 u_bcd (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr_s),
        .inc    (cnt_inc_s),
        .digits (digits_s),
        .at_max (at_max_s)
    );

    // FSM next state, delay countdown and counter control
    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        overflow_d  = overflow_q;
        presc_clr_s = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start) begin
                    state_d     = ST_DELAY;
                    delay_d     = DELAY_BASE + {1'b0, lfsr_q[9:0]};
                    overflow_d  = 1'b0;
                    presc_clr_s = 1'b1;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DELAY: begin
                // an early reaction wins even on the expiry tick
                if (stop) begin
                    state_d = ST_FAULT;
                end else if (tick_s) begin
                    delay_d = delay_q - 11'd1;
                    if (delay_q <= 11'd1) begin
                        state_d     = ST_TIMING;
                        presc_clr_s = 1'b1;
                    end else begin
                        state_d = ST_DELAY;
                    end
                end else begin
                    state_d = ST_DELAY;
                end
            end
            ST_TIMING: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (tick_s && at_max_s) begin
                    state_d    = ST_DONE;
                    overflow_d = 1'b1;
                end else if (tick_s) begin
                    cnt_inc_s = 1'b1;
                end else begin
                    state_d = ST_TIMING;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Prescaler and LFSR next values
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        if (presc_clr_s || tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            delay_q    <= 11'd0;
            lfsr_q     <= LFSR_SEED;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            delay_q    <= delay_d;
            lfsr_q     <= lfsr_d;
            overflow_q <= overflow_d;
        end
    end

    assign thousandths = digits_s[0];
    assign hundreths   = digits_s[1];
    assign tenths      = digits_s[2];
    assign ones        = digits_s[3];
    assign disp_en     = (state_q == ST_TIMING) || (state_q == ST_DONE);
    assign led         = (state_q == ST_TIMING);
    assign overflow    = overflow_q;
    assign state       = state_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed self-checking bench for reaction_timer_ctrl with TICK_DIV=4.
module tb_reaction_timer_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] ones, tenths, hundreths, thousandths;
    logic       disp_en, led, overflow;
    logic [2:0] state;
    logic [15:0] dig;
    logic [15:0] m_lfsr;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_delay = 0;

    reaction_timer_ctrl #(.TICK_DIV(4), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .ones(ones), .tenths(tenths), .hundreths(hundreths), .thousandths(thousandths),
        .disp_en(disp_en), .led(led), .overflow(overflow), .state(state)
    );

    always #5 clk = ~clk;

    assign dig = {ones, tenths, hundreths, thousandths};

    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic do_start(input bit want_small);
        int w;
        w = 0;
        while (want_small && m_lfsr[9:0] >= 10'd16 && w < 5000) begin
            @(posedge clk); #1; w++;
        end
        exp_delay = 1000 + int'(m_lfsr[9:0]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL start_state: got %0d expected 1", state); end
        n_cmp++; if (dig !== 16'h0000 || overflow !== 1'b0 || led !== 1'b0) begin
            n_bad++; $display("FAIL start_clear: dig=%h ovf=%b led=%b expected 0000/0/0", dig, overflow, led);
        end
    endtask

    task automatic wait_led();
        int cyc;
        cyc = 1;
        while (led !== 1'b1 && cyc < 9000) begin
            @(posedge clk); #1; cyc++;
        end
        n_cmp++; if (cyc != exp_delay * 4 + 1) begin
            n_bad++; $display("FAIL led_latency: got %0d expected %0d", cyc, exp_delay * 4 + 1);
        end
        n_cmp++; if (state !== 3'd2 || disp_en !== 1'b1) begin
            n_bad++; $display("FAIL timing_entry: state=%0d disp_en=%b expected 2/1", state, disp_en);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (state !== 3'd0 || dig !== 16'h0000 || disp_en !== 1'b0 || led !== 1'b0 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL reset_outputs: state=%0d dig=%h en=%b led=%b ovf=%b expected all 0", state, dig, disp_en, led, overflow);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_over_start: got %0d expected 0", state); end
        rst = 1'b0;
        pulse_stop();
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL idle_stop_ignored: got %0d expected 0", state); end
    endtask

    task automatic test_first_run();
        repeat (5) @(posedge clk);
        #1;
        do_start(1'b0);
        wait_led();
        repeat (4936) @(posedge clk);
        #1;
        pulse_stop();
        n_cmp++; if (state !== 3'd3 || led !== 1'b0 || disp_en !== 1'b1) begin
            n_bad++; $display("FAIL stop_done: state=%0d led=%b en=%b expected 3/0/1", state, led, disp_en);
        end
        n_cmp++; if (dig !== 16'h1234) begin n_bad++; $display("FAIL count_1234: got %h expected 1234", dig); end
        repeat (100) @(posedge clk);
        #1;
        n_cmp++; if (dig !== 16'h1234 || state !== 3'd3 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL done_hold: dig=%h state=%0d ovf=%b expected 1234/3/0", dig, state, overflow);
        end
    endtask

    task automatic test_fault();
        do_start(1'b1);
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL delay_start_ignored: got %0d expected 1", state); end
        pulse_stop();
        n_cmp++; if (state !== 3'd4 || led !== 1'b0 || dig !== 16'h0000 || disp_en !== 1'b0) begin
            n_bad++; $display("FAIL early_stop_fault: state=%0d led=%b dig=%h en=%b expected 4/0/0000/0", state, led, dig, disp_en);
        end
    endtask

    task automatic test_expiry_fault();
        do_start(1'b1);
        repeat (exp_delay * 4 - 1) @(posedge clk);
        #1;
        pulse_stop();
        n_cmp++; if (state !== 3'd4 || led !== 1'b0) begin
            n_bad++; $display("FAIL expiry_stop_fault: state=%0d led=%b expected 4/0", state, led);
        end
    endtask

    task automatic test_saturation();
        int n;
        do_start(1'b1);
        wait_led();
        n = 0;
        while (state !== 3'd3 && n < 41000) begin
            @(posedge clk); #1; n++;
        end
        n_cmp++; if (n != 40000) begin n_bad++; $display("FAIL saturate_cycles: got %0d expected 40000", n); end
        n_cmp++; if (dig !== 16'h9999 || overflow !== 1'b1 || led !== 1'b0) begin
            n_bad++; $display("FAIL saturate_value: dig=%h ovf=%b led=%b expected 9999/1/0", dig, overflow, led);
        end
    endtask

    task automatic test_carry_stop(input int ticks, input logic [15:0] exp_dig);
        do_start(1'b1);
        wait_led();
        repeat (ticks * 4 - 1) @(posedge clk);
        #1;
        pulse_stop();
        n_cmp++; if (dig !== exp_dig || state !== 3'd3) begin
            n_bad++; $display("FAIL carry_stop_%0d: dig=%h state=%0d expected %h/3", ticks, dig, state, exp_dig);
        end
    endtask

    task automatic test_reset_mid_run();
        do_start(1'b1);
        wait_led();
        repeat (2000) @(posedge clk);
        #1;
        n_cmp++; if (dig !== 16'h0500) begin n_bad++; $display("FAIL count_0500: got %h expected 0500", dig); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (state !== 3'd0 || dig !== 16'h0000 || disp_en !== 1'b0 || led !== 1'b0 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL midrun_reset: state=%0d dig=%h en=%b led=%b ovf=%b expected all 0", state, dig, disp_en, led, overflow);
        end
        n_cmp++; if (dut.lfsr_q !== SEED) begin n_bad++; $display("FAIL lfsr_reseed: got %h expected %h", dut.lfsr_q, SEED); end
    endtask

    initial begin
        test_reset();
        test_first_run();
        test_fault();
        test_expiry_fault();
        test_saturation();
        test_carry_stop(10, 16'h0009);
        test_carry_stop(100, 16'h0099);
        test_carry_stop(1000, 16'h0999);
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reaction_timer_ctrl.md
REACTION_TIMER_CTRL -- requirements
Module: reaction_timer_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning clocks per 1 ms tick (legal range 2..2^20).
REQ-002 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning reset value of the delay LFSR (nonzero).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 start  input  1  single-cycle pulse, already debounced and synchronized; begins a run.
REQ-006 stop  input  1  single-cycle pulse, already debounced and synchronized; player reaction.
REQ-007 ones, tenths, hundreths, thousandths  output  4 each  BCD digits of elapsed time (s.mmm), feeding the seven-segment decoder.
REQ-008 disp_en  output  1  digits valid; high in TIMING and DONE only.
REQ-009 led  output  1  go-stimulus lamp; high in TIMING only.
REQ-010 overflow  output  1  set when the count saturated at 9.999.
REQ-011 state  output  3  current FSM state code.

Function
REQ-012 SHALL implement a Moore FSM: IDLE=0, DELAY=1, TIMING=2, DONE=3, FAULT=4; codes 5-7 SHALL return to IDLE next cycle.
REQ-013 IDLE: start -> DELAY; stop ignored.
REQ-014 On the start cycle, SHALL load the delay counter with 1000 + lfsr[9:0] ms (1000..2023), clear all digits to 0, and clear overflow.
REQ-015 DELAY: stop -> FAULT; delay counter reaching 0 on a tick -> TIMING; start ignored.
REQ-016 DELAY: stop on the same cycle as expiry SHALL give FAULT.
REQ-017 TIMING: each tick SHALL increment the 4-digit BCD count by 1 (0.001 s), with carry from thousandths up to ones.
REQ-018 TIMING: stop -> DONE and freezes the count; stop on a tick cycle SHALL take priority, with no increment.
REQ-019 TIMING: a tick while the count is 9.999 SHALL hold 9.999, set overflow, and go to DONE.
REQ-020 DONE and FAULT: start -> DELAY, following REQ-014; stop ignored.
REQ-021 Digits SHALL hold their value in DONE, and SHALL read 0 in IDLE, DELAY and FAULT.
REQ-022 Tick prescaler: counts 0..TICK_DIV-1 and pulses the tick when it wraps; SHALL be cleared on entry to DELAY and on entry to TIMING.
REQ-023 The first tick after each prescaler clear SHALL come exactly TICK_DIV cycles later.
REQ-024 LFSR: 16-bit Fibonacci, taps 16,14,13,11; SHALL advance every clock cycle in all states.
REQ-025 The start-to-led latency SHALL be exactly (delay_ms x TICK_DIV) + 1 cycles.
REQ-026 All outputs SHALL be registered, or decoded from registered state only.

Reset
REQ-027 With rst high, the next edge SHALL set: state=IDLE, digits=0, disp_en=0, led=0, overflow=0, prescaler=0, delay counter=0, lfsr=LFSR_SEED.
REQ-028 rst SHALL override start and stop on the same cycle.
REQ-029 rst asserted mid-run (DELAY or TIMING) SHALL abort to IDLE with no residual count.

Structure
REQ-030 A shared package SHALL hold: the state encoding enum, LFSR_SEED default, LFSR tap mask, DELAY_BASE=1000, and the BCD max value 9.999.
REQ-031 One sub-module, bcd_counter4, SHALL implement the clear, increment-enable, saturate-at-9999 and at_max flag.
REQ-032 The FSM, prescaler, LFSR and delay counter SHALL remain in reaction_timer_ctrl.

Verification (TICK_DIV=4; delay taken from a bench LFSR model)
REQ-033 Reset, then start at cycle 10 -> state=1; led rises exactly (delay_ms x 4)+1 cycles later; state=2, disp_en=1.
REQ-034 In TIMING, stop after 1234 ticks -> state=3; digits 1,2,3,4; led=0; digits held for 100 further cycles.
REQ-035 stop during DELAY -> state=4, led stays 0, digits=0; next start -> state=1 with a fresh delay.
REQ-036 No stop for 10000 ticks -> digits saturate at 9,9,9,9; overflow=1; state=3.
REQ-037 stop on the exact tick cycle taking the count 0.099 -> 0.100 -> count frozen at 0.099, and so on for each carry boundary (0.009, 0.999).
REQ-038 rst pulsed mid-TIMING at count 0.500 -> next cycle all outputs 0, state=0; lfsr=LFSR_SEED.
